// File: rtl/id_ex_skid_reg.sv
// Decode-to-execute pipeline register with valid/ready handshake,
// a 2-entry skid buffer (main + skid) and a flush that squashes in-flight work.
module id_ex_skid_reg #(
  parameter int unsigned          CTRL_W   = 8,
  parameter int unsigned          DATA_W   = 128,
  parameter logic [DATA_W-1:0]    RST_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  localparam int unsigned OCC_W = 2;

  // Main entry drives the outputs; skid entry absorbs one beat of back-pressure.
  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;

  logic acc_c;
  logic pop_c;

  // Handshake events; ready comes purely from the skid register.
  assign acc_c = in_valid_i & ~s_valid_q;
  assign pop_c = m_valid_q & out_ready_i;

  // Next-state: occupancy transitions, flush squash; control is cleared
  // whenever the main entry empties so a bubble never carries enables.
  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;

    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_ctrl_d  = '0;
    end else begin
      unique case ({m_valid_q, s_valid_q})
        2'b00: begin
          if (acc_c) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = in_ctrl_i;
            m_data_d  = in_data_i;
          end
        end
        2'b10: begin
          if (pop_c && acc_c) begin
            m_ctrl_d  = in_ctrl_i;
            m_data_d  = in_data_i;
          end else if (pop_c) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
          end else if (acc_c) begin
            s_valid_d = 1'b1;
            s_ctrl_d  = in_ctrl_i;
            s_data_d  = in_data_i;
          end
        end
        2'b11: begin
          if (pop_c) begin
            m_ctrl_d  = s_ctrl_q;
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
            s_ctrl_d  = '0;
          end
        end
        default: begin
          // Skid without main is unreachable; recover to empty if it ever appears.
          m_valid_d = 1'b0;
          s_valid_d = 1'b0;
          m_ctrl_d  = '0;
          s_ctrl_d  = '0;
        end
      endcase
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= RST_DATA;
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= RST_DATA;
    end else begin
      m_valid_q <= m_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
    end
  end

  // Outputs come straight from the entry registers.
  assign in_ready_o  = ~s_valid_q;
  assign out_valid_o = m_valid_q;
  assign out_ctrl_o  = m_ctrl_q;
  assign out_data_o  = m_data_q;
  assign occupancy_o = OCC_W'(m_valid_q) + OCC_W'(s_valid_q);

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_id_ex_skid_reg;

  localparam int unsigned CTRL_W = 8;
  localparam int unsigned DATA_W = 128;
  localparam logic [DATA_W-1:0] RST_VAL = 128'h5EED;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } item_t;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occ;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  item_t             q[$];
  logic [DATA_W-1:0] last_data = RST_VAL;
  bit                data_known = 1'b0;
  bit                model_live = 1'b0;

  always #5 clk = ~clk;

  id_ex_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RST_DATA(RST_VAL)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_ctrl_o(out_ctrl), .out_data_o(out_data),
    .occupancy_o(occ)
  );

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model's view of the queue.
  task automatic model_check();
    bit v;
    v = (q.size() > 0);
    chk("out_valid", DATA_W'(out_valid), DATA_W'(v));
    chk("in_ready",  DATA_W'(in_ready),  DATA_W'(q.size() < 2));
    chk("occupancy", DATA_W'(occ),       DATA_W'(q.size()));
    chk("out_ctrl",  DATA_W'(out_ctrl),  v ? DATA_W'(q[0].c) : '0);
    if (v)               chk("out_data", out_data, q[0].d);
    else if (data_known) chk("out_data_hold", out_data, last_data);
  endtask

  // One clock: drive after negedge, check, then advance model at posedge.
  task automatic cycle(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input bit ordy, input bit fl, input bit rs);
    bit acc, pop;
    item_t it;
    @(negedge clk);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; rst = rs;
    #1;
    if (model_live) model_check();
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    it.c = c; it.d = d;
    @(posedge clk);
    if (rs) begin
      q.delete(); last_data = RST_VAL; data_known = 1'b1; model_live = 1'b1;
    end else if (fl) begin
      q.delete(); data_known = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(it);
    end
    if (q.size() > 0) begin
      last_data = q[0].d; data_known = 1'b1;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    // Reset
    cycle(0, '0, '0, 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 1);
    chk("rst_valid", DATA_W'(out_valid), '0);
    chk("rst_ready", DATA_W'(in_ready), DATA_W'(1));
    chk("rst_occ", DATA_W'(occ), '0);
    chk("rst_data", out_data, RST_VAL);

    // Stream 1..4 at full throughput
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 8'h01, DATA_W'(k), 1, 0, 0);
      chk("stream_data", out_data, DATA_W'(k));
      chk("stream_occ", DATA_W'(occ), DATA_W'(1));
      chk("stream_ready", DATA_W'(in_ready), DATA_W'(1));
    end
    cycle(0, '0, '0, 1, 0, 0);
    chk("stream_drain", DATA_W'(out_valid), '0);

    // Back-pressure
    cycle(1, 8'h02, DATA_W'('hA), 0, 0, 0);
    cycle(1, 8'h02, DATA_W'('hB), 0, 0, 0);
    chk("bp_ready", DATA_W'(in_ready), '0);
    chk("bp_occ", DATA_W'(occ), DATA_W'(2));
    chk("bp_data", out_data, DATA_W'('hA));
    cycle(1, 8'h02, DATA_W'('hC), 0, 0, 0);
    chk("bp_hold", out_data, DATA_W'('hA));
    cycle(1, 8'h02, DATA_W'('hC), 1, 0, 0);
    chk("bp_second", out_data, DATA_W'('hB));
    cycle(1, 8'h02, DATA_W'('hC), 1, 0, 0);
    chk("bp_third", out_data, DATA_W'('hC));
    cycle(0, '0, '0, 1, 0, 0);
    chk("bp_empty", DATA_W'(occ), '0);

    // Bubble control
    cycle(1, 8'hFF, DATA_W'('h33), 0, 0, 0);
    chk("bub_ctrl_on", DATA_W'(out_ctrl), DATA_W'(8'hFF));
    cycle(0, '0, '0, 1, 0, 0);
    chk("bub_valid", DATA_W'(out_valid), '0);
    chk("bub_ctrl", DATA_W'(out_ctrl), '0);
    chk("bub_data", out_data, DATA_W'('h33));

    // Flush in FULL state
    cycle(1, 8'h11, DATA_W'('h11), 0, 0, 0);
    cycle(1, 8'h22, DATA_W'('h22), 0, 0, 0);
    cycle(1, 8'h55, DATA_W'('h55), 0, 1, 0);
    chk("fl_occ", DATA_W'(occ), '0);
    chk("fl_valid", DATA_W'(out_valid), '0);
    chk("fl_ctrl", DATA_W'(out_ctrl), '0);
    chk("fl_ready", DATA_W'(in_ready), DATA_W'(1));
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    chk("fl_no55", DATA_W'(out_valid), '0);

    // Reset mid-stall
    cycle(1, 8'h0F, DATA_W'('h44), 0, 0, 0);
    cycle(1, 8'h0F, DATA_W'('h45), 0, 0, 0);
    chk("rs_full", DATA_W'(occ), DATA_W'(2));
    cycle(1, 8'h0F, DATA_W'('h46), 0, 1, 1);
    chk("rs_occ", DATA_W'(occ), '0);
    chk("rs_valid", DATA_W'(out_valid), '0);
    chk("rs_ctrl", DATA_W'(out_ctrl), '0);
    chk("rs_data", out_data, RST_VAL);
    cycle(1, 8'h07, DATA_W'('h77), 0, 0, 0);
    chk("rs_first_occ", DATA_W'(occ), DATA_W'(1));
    chk("rs_first_data", out_data, DATA_W'('h77));
    cycle(0, '0, '0, 1, 0, 0);
    chk("rs_alone", DATA_W'(occ), '0);

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      cycle(($urandom_range(0, 3) != 0),
            CTRL_W'($urandom),
            {$urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 499) == 0));
    end
    cycle(0, '0, '0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
